// File: rtl/adc_spi_responder.sv
// SPI-slave emulator of a WIDTH-bit ADC: convst starts a conversion, sclk falls shift the
// code out MSB first on miso. Codes come from a ramp counter, a 16-bit LFSR or a fixed value.
module adc_spi_responder #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned T_POWER_UP = 150,
  parameter int unsigned T_CONV     = 230
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             convst,
  input  logic             sclk,
  output logic             miso,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] fixed_code,
  output logic             busy
);

  localparam int unsigned CNT_MAX = (T_POWER_UP > T_CONV) ? T_POWER_UP : T_CONV;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(WIDTH);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    S_POWERUP = 2'd0,
    S_IDLE    = 2'd1,
    S_CONVERT = 2'd2,
    S_SHIFT   = 2'd3
  } state_t;

  state_t             state, state_next;
  logic               convst_s1, convst_s2, convst_d;
  logic               sclk_s1, sclk_s2, sclk_d;
  logic               conv_rise, sclk_fall;
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WIDTH-1:0]   sreg;
  logic [WIDTH-1:0]   ramp;
  logic [15:0]        lfsr;
  logic [1:0]         mode_r;
  logic [WIDTH-1:0]   fixed_r;
  logic [WIDTH-1:0]   code;
  logic               pu_done, conv_done, last_bit;
  logic               start, load, shift_en;
  logic               busy_next, miso_next;

  assign conv_rise = convst_s2 & ~convst_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign pu_done   = (cnt == CNT_W'(T_POWER_UP - 1));
  assign conv_done = (cnt == CNT_W'(T_CONV - 1));
  assign last_bit  = (bit_cnt == BIT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_POWERUP;
    else     state <= state_next;
  end

  // Next-state logic; a convst rise in SHIFT takes priority over a same-cycle sclk fall
  always_comb begin
    state_next = state;
    case (state)
      S_POWERUP: if (pu_done)   state_next = S_IDLE;
      S_IDLE:    if (conv_rise) state_next = S_CONVERT;
      S_CONVERT: if (conv_done) state_next = S_SHIFT;
      S_SHIFT: begin
        if (conv_rise)                 state_next = S_CONVERT;
        else if (sclk_fall && last_bit) state_next = S_IDLE;
      end
      default:                  state_next = S_POWERUP;
    endcase
  end

  // Output / datapath control; miso follows the shift register one cycle after it moves
  always_comb begin
    start     = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    busy_next = 1'b0;
    miso_next = 1'b0;
    code      = fixed_r;
    case (mode_r)
      2'd0:    code = ramp;
      2'd1:    code = lfsr[WIDTH-1:0];
      default: code = fixed_r;
    endcase
    start     = conv_rise && (state == S_IDLE || state == S_SHIFT);
    load      = (state == S_CONVERT) && conv_done;
    shift_en  = (state == S_SHIFT) && sclk_fall && !conv_rise;
    busy_next = (state_next == S_POWERUP) || (state_next == S_CONVERT);
    if (load)                                  miso_next = code[WIDTH-1];
    else if (state == S_SHIFT && !conv_rise)   miso_next = sreg[WIDTH-1];
  end

  // Synchronizers and edge-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      convst_s1 <= 1'b0;
      convst_s2 <= 1'b0;
      convst_d  <= 1'b0;
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      convst_s1 <= convst;
      convst_s2 <= convst_s1;
      convst_d  <= convst_s2;
      sclk_s1   <= sclk;
      sclk_s2   <= sclk_s1;
      sclk_d    <= sclk_s2;
    end
  end

  // Counters, code sources, shift register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      sreg    <= '0;
      ramp    <= '0;
      lfsr    <= LFSR_SEED;
      mode_r  <= 2'd0;
      fixed_r <= '0;
      busy    <= 1'b1;
      miso    <= 1'b0;
    end else begin
      if (start)
        cnt <= '0;
      else if (state == S_POWERUP || state == S_CONVERT)
        cnt <= cnt + CNT_W'(1);

      if (start) begin
        mode_r  <= mode;
        fixed_r <= fixed_code;
      end

      if (load) begin
        sreg    <= code;
        bit_cnt <= '0;
        if (mode_r == 2'd0) ramp <= ramp + WIDTH'(1);
        if (mode_r == 2'd1) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end else if (shift_en) begin
        sreg    <= {sreg[WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end

      busy <= busy_next;
      miso <= miso_next;
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench: drivers push expected codes and busy widths, monitors pop and compare.
module tb_adc_spi_responder;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [1:0] convst, sclk, miso, busy;
  logic [1:0] mode [2];
  logic [9:0] fixed_code [2];

  int errors = 0;
  int checks = 0;
  bit pu_done = 1'b0;

  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  int         width_q[$];

  always #5 clk = ~clk;

  adc_spi_responder #(.WIDTH(10), .T_POWER_UP(150), .T_CONV(230)) dut_a (
    .clk(clk), .rst(rst_a), .convst(convst[0]), .sclk(sclk[0]), .miso(miso[0]),
    .mode(mode[0]), .fixed_code(fixed_code[0]), .busy(busy[0]));

  adc_spi_responder #(.WIDTH(10), .T_POWER_UP(4), .T_CONV(4)) dut_b (
    .clk(clk), .rst(rst_b), .convst(convst[1]), .sclk(sclk[1]), .miso(miso[1]),
    .mode(mode[1]), .fixed_code(fixed_code[1]), .busy(busy[1]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_code(input int g, input logic [9:0] act);
    logic [9:0] e;
    if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL code%0d: unexpected transfer 0x%0h", g, act);
    end else begin
      e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("code%0d", g), int'(act), int'(e));
    end
  endtask

  // Receive monitors: collect miso on sclk rise, restart on any busy assertion
  for (genvar g = 0; g < 2; g++) begin : g_mon
    int         nb = 0;
    logic [9:0] sh = '0;
    always @(posedge sclk[g] or posedge busy[g]) begin
      if (busy[g]) nb = 0;
      else if (nb < 10) begin
        sh = {sh[8:0], miso[g]};
        nb++;
        if (nb == 10) check_code(g, sh);
      end
    end
  end

  // Busy-width monitor for the full-timing instance
  int wcnt = 0;
  always @(negedge clk) begin
    if (!pu_done) wcnt = 0;
    else if (busy[0]) wcnt++;
    else if (wcnt != 0) begin
      if (width_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL busy_width: unexpected pulse of %0d cycles", wcnt);
      end else check("busy_width", wcnt, width_q.pop_front());
      wcnt = 0;
    end
  end

  task automatic conv(input int i, input logic [1:0] m, input logic [9:0] fx,
                      input int nbits, input bit push, input logic [9:0] exp);
    int n;
    @(negedge clk);
    mode[i]       = m;
    fixed_code[i] = fx;
    convst[i]     = 1'b1;
    if (push) begin
      if (i == 0) exp_q0.push_back(exp);
      else        exp_q1.push_back(exp);
    end
    if (i == 0) width_q.push_back(230);
    repeat (4) @(negedge clk);
    convst[i] = 1'b0;
    n = 0;
    while (busy[i] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall", int'(busy[i]), 0);
    repeat (2) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      sclk[i] = 1'b1;
      repeat (4) @(negedge clk);
      sclk[i] = 1'b0;
      repeat (4) @(negedge clk);
    end
    if (nbits == 10) check("miso_idle", int'(miso[i]), 0);
  endtask

  initial begin
    int  n;
    bit  quiet;
    convst = '0;
    sclk   = '0;
    mode[0] = 2'd0; mode[1] = 2'd0;
    fixed_code[0] = '0; fixed_code[1] = '0;
    rst_a = 1'b1;
    rst_b = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy[0]), 1);
    check("reset_miso", int'(miso[0]), 0);

    // Power-up: convst pulse at 500 ns must be ignored
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    n = 0;
    quiet = 1'b1;
    while (busy[0] && n < 1000) begin
      if (miso[0]) quiet = 1'b0;
      if (n == 50) convst[0] = 1'b1;
      if (n == 54) convst[0] = 1'b0;
      n++;
      @(negedge clk);
    end
    check("powerup_width", n, 150);
    for (int k = 0; k < 300; k++) begin
      if (busy[0] || miso[0]) quiet = 1'b0;
      @(negedge clk);
    end
    check("powerup_quiet", int'(quiet), 1);
    pu_done = 1'b1;

    // Ramp, fixed and LFSR codes
    conv(0, 2'd0, 10'h000, 10, 1'b1, 10'h000);
    conv(0, 2'd0, 10'h000, 10, 1'b1, 10'h001);
    conv(0, 2'd0, 10'h000, 10, 1'b1, 10'h002);
    conv(0, 2'd2, 10'h2AA, 10, 1'b1, 10'h2AA);
    conv(0, 2'd3, 10'h155, 10, 1'b1, 10'h155);
    conv(0, 2'd1, 10'h000, 10, 1'b1, 10'h0E1);
    conv(0, 2'd1, 10'h000, 10, 1'b1, 10'h270);

    // Asynchronous reset in the middle of a transfer with miso high
    conv(0, 2'd2, 10'h3FF, 3, 1'b0, 10'h000);
    pu_done = 1'b0;
    check("pre_reset_miso", int'(miso[0]), 1);
    #2;
    rst_a = 1'b1;
    #1;
    check("midreset_busy", int'(busy[0]), 1);
    check("midreset_miso", int'(miso[0]), 0);
    @(negedge clk);
    rst_a = 1'b0;
    n = 0;
    while (busy[0] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("repowerup_done", int'(busy[0]), 0);
    pu_done = 1'b1;

    // Abort after 4 bits, then a full transfer of the next ramp code
    conv(0, 2'd0, 10'h000, 4, 1'b0, 10'h000);
    conv(0, 2'd0, 10'h000, 10, 1'b1, 10'h001);

    // Ramp wrap on the short-timing instance: 1023 quick conversions, then two full ones
    for (int k = 0; k < 1023; k++) begin
      @(negedge clk);
      mode[1]   = 2'd0;
      convst[1] = 1'b1;
      repeat (3) @(negedge clk);
      convst[1] = 1'b0;
      repeat (12) @(negedge clk);
    end
    conv(1, 2'd0, 10'h000, 10, 1'b1, 10'h3FF);
    conv(1, 2'd0, 10'h000, 10, 1'b1, 10'h000);

    repeat (20) @(negedge clk);
    check("queue0_empty", exp_q0.size(), 0);
    check("queue1_empty", exp_q1.size(), 0);
    check("width_queue_empty", width_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
